// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath blocks.
//   WIDTH    : datapath width, shared with the ALU
//   REG_AW   : register-file address width
//   REG_ZERO : address of the hard-wired $zero register
//   state_e  : register-file sweep controller states
package mips_pkg;

   localparam int WIDTH  = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1
   } state_e;

endpackage

// File: rtl/reg_file_clear_ctl.sv
// Post-reset sweep controller for the register file. Walks ptr across
// every entry, asserting clr_we so the top writes zero there, then parks in
// RUN with ready high.
//   clk      : system clock
//   rst      : synchronous reset, active-high; restarts the sweep
//   clr_we   : write strobe for the zeroing sweep
//   clr_addr : entry being zeroed
//   ready    : sweep finished, file usable
//
// state | meaning
// ------+--------------------------------------------------
// CLEAR | zeroing mem[ptr] each edge, ready low
// RUN   | sweep done, ready high, external port owns writes
module reg_file_clear_ctl
   import mips_pkg::*;
#(
   parameter int AW = REG_AW
) (
   input  logic          clk,
   input  logic          rst,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          ready
);

   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // ptr wraps to 0 on the same edge that leaves CLEAR.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == '1) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   // A reset edge must not write, even while still in CLEAR.
   always_comb begin
      clr_we   = (state_q == CLEAR) && !rst;
      clr_addr = ptr_q;
      ready    = (state_q == RUN);
   end

endmodule

// File: rtl/reg_file.sv
// 32-entry general-purpose register file feeding the ALU operands.
// Storage has no per-entry reset; the clear controller zeroes it after
// reset and holds ready low until done. Reads are asynchronous.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   ra1/ra2 : read addresses (rs / rt)
//   rd1/rd2 : read data (ALU A / ALU B mux)
//   we/wa/wd: writeback port
//   ready   : file is usable
module reg_file #(
   parameter int WIDTH  = mips_pkg::WIDTH,
   parameter int AW     = mips_pkg::REG_AW,
   parameter bit BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   output logic             ready
);

   import mips_pkg::*;

   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [WIDTH-1:0] mem [2**AW];

   logic             clr_we;
   logic [AW-1:0]    clr_addr;

   logic             ext_we;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   reg_file_clear_ctl #(
      .AW (AW)
   ) u_clear_ctl (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   // External write that will really commit at this edge.
   assign ext_we = ready && !rst && we && (wa != ZERO_ADDR);

   always_comb begin
      wr_en   = ext_we;
      wr_addr = wa;
      wr_data = wd;
      if (!ready) begin
         wr_en   = clr_we;
         wr_addr = clr_addr;
         wr_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ready) begin
         if (ra1 != ZERO_ADDR) rd1 = (BYPASS && ext_we && (wa == ra1)) ? wd : mem[ra1];
         if (ra2 != ZERO_ADDR) rd2 = (BYPASS && ext_we && (wa == ra2)) ? wd : mem[ra2];
      end
   end

endmodule
